// File: rtl/emit2_pkg.sv
// Shared dispenser definitions: stage-2 FSM encoding, default sizing and
// handshake phase names used by both the stage-1 emitter and emit2.
package emit2_pkg;

  localparam int AMT_W_DEF    = 8;
  localparam int TICK_DIV_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POUR = 2'd1,
    ST_ACK  = 2'd2
  } emit2_state_t;

  // Four-phase count/count_ACK handshake as seen from either end
  typedef enum logic [1:0] {
    PH_REQ_RAISE = 2'd0,
    PH_ACK_RAISE = 2'd1,
    PH_REQ_DROP  = 2'd2,
    PH_ACK_DROP  = 2'd3
  } hs_phase_t;

  // Prescaler width; a divider of 1 still needs one bit of storage
  function automatic int presc_w(input int tick_div);
    return (tick_div <= 1) ? 1 : $clog2(tick_div);
  endfunction

endpackage

// File: rtl/emit2_datapath.sv
// Stage-2 pour counters: remaining units, delivered units and the tick prescaler.
module emit2_datapath
  import emit2_pkg::*;
#(
  parameter int AMT_W    = AMT_W_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             load,
  input  logic             clear,
  input  logic             en,
  input  logic [AMT_W-1:0] amount,
  output logic [AMT_W-1:0] poured,
  output logic             last_tick
);

  localparam int PW = presc_w(TICK_DIV);

  logic [PW-1:0]    presc_r;
  logic [AMT_W-1:0] rem_r;
  logic [AMT_W-1:0] poured_r;
  logic             wrap_s;

  assign wrap_s    = (presc_r == PW'(TICK_DIV - 1));
  assign last_tick = wrap_s && (rem_r == AMT_W'(1));
  assign poured    = poured_r;

  // Counter registers: load on acceptance, clear for zero-amount requests, count while pouring
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      presc_r  <= {PW{1'b0}};
      rem_r    <= {AMT_W{1'b0}};
      poured_r <= {AMT_W{1'b0}};
    end else if (load) begin
      presc_r  <= {PW{1'b0}};
      rem_r    <= amount;
      poured_r <= {AMT_W{1'b0}};
    end else if (clear) begin
      presc_r  <= {PW{1'b0}};
      rem_r    <= {AMT_W{1'b0}};
      poured_r <= {AMT_W{1'b0}};
    end else if (en) begin
      if (wrap_s) begin
        presc_r  <= {PW{1'b0}};
        rem_r    <= rem_r - AMT_W'(1);
        poured_r <= poured_r + AMT_W'(1);
      end else begin
        presc_r  <= presc_r + PW'(1);
      end
    end else begin
      presc_r  <= presc_r;
      rem_r    <= rem_r;
      poured_r <= poured_r;
    end
  end

endmodule

// File: rtl/emit2.sv
// Stage-2 pour responder: accepts a count2 request, drives out2 for
// amount2 x TICK_DIV cycles, then completes the four-phase acknowledge.
module emit2
  import emit2_pkg::*;
#(
  parameter int AMT_W    = AMT_W_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             count2,
  input  logic [AMT_W-1:0] amount2,
  input  logic             stop2,
  output logic             count_ACK2,
  output logic             out2,
  output logic             busy2,
  output logic             aborted2,
  output logic [AMT_W-1:0] poured2
);

  emit2_state_t state_r, state_nx_s;
  logic         load_s, clear_s, en_s, last_tick_s;
  logic         aborted_nx_s;
  logic         out2_r, ack_r, busy_r, aborted_r;

  emit2_datapath #(
    .AMT_W    (AMT_W),
    .TICK_DIV (TICK_DIV)
  ) u_datapath (
    .clk       (clk),
    .RESET     (RESET),
    .load      (load_s),
    .clear     (clear_s),
    .en        (en_s),
    .amount    (amount2),
    .poured    (poured2),
    .last_tick (last_tick_s)
  );

  // Next-state and datapath control; a withdrawn request outranks stop2
  always_comb begin
    state_nx_s   = state_r;
    load_s       = 1'b0;
    clear_s      = 1'b0;
    en_s         = 1'b0;
    aborted_nx_s = aborted_r;
    case (state_r)
      ST_IDLE: begin
        if (count2) begin
          aborted_nx_s = 1'b0;
          if (amount2 != {AMT_W{1'b0}}) begin
            load_s     = 1'b1;
            state_nx_s = ST_POUR;
          end else begin
            clear_s    = 1'b1;
            state_nx_s = ST_ACK;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_POUR: begin
        if (!count2) begin
          aborted_nx_s = 1'b0;
          state_nx_s   = ST_IDLE;
        end else if (stop2) begin
          aborted_nx_s = 1'b1;
          state_nx_s   = ST_ACK;
        end else begin
          en_s = 1'b1;
          if (last_tick_s) begin
            state_nx_s = ST_ACK;
          end else begin
            state_nx_s = ST_POUR;
          end
        end
      end
      ST_ACK: begin
        if (!count2) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_ACK;
        end
      end
      default: begin
        aborted_nx_s = 1'b0;
        state_nx_s   = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, decoded from the next state so they align with it
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_r   <= ST_IDLE;
      out2_r    <= 1'b0;
      ack_r     <= 1'b0;
      busy_r    <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      out2_r    <= (state_nx_s == ST_POUR);
      ack_r     <= (state_nx_s == ST_ACK);
      busy_r    <= (state_nx_s != ST_IDLE);
      aborted_r <= aborted_nx_s;
    end
  end

  assign out2       = out2_r;
  assign count_ACK2 = ack_r;
  assign busy2      = busy_r;
  assign aborted2   = aborted_r;

endmodule

// File: tb/tb_emit2.sv
// Directed self-checking bench for emit2 (AMT_W=8, TICK_DIV=4).
module tb_emit2;

  logic       clk = 1'b0;
  logic       RESET = 1'b0;
  logic       count2 = 1'b0;
  logic [7:0] amount2 = 8'd0;
  logic       stop2 = 1'b0;
  logic       count_ACK2, out2, busy2, aborted2;
  logic [7:0] poured2;

  int n_checks = 0;
  int n_fail   = 0;

  emit2 #(.AMT_W(8), .TICK_DIV(4)) dut (
    .clk        (clk),
    .RESET      (RESET),
    .count2     (count2),
    .amount2    (amount2),
    .stop2      (stop2),
    .count_ACK2 (count_ACK2),
    .out2       (out2),
    .busy2      (busy2),
    .aborted2   (aborted2),
    .poured2    (poured2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Counts out2-high negedges until count_ACK2 rises or the budget runs out
  task automatic run_to_ack(input int budget, output int outs, output logic got_ack);
    outs    = 0;
    got_ack = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out2) outs++;
      if (count_ACK2) begin
        got_ack = 1'b1;
        break;
      end
    end
  endtask

  int   outs;
  logic got_ack;
  logic seen;

  initial begin
    // Reset state
    #12;
    check_eq("rst_out2", out2, 0);
    check_eq("rst_ack", count_ACK2, 0);
    check_eq("rst_busy", busy2, 0);
    check_eq("rst_poured", poured2, 0);
    @(negedge clk);
    RESET = 1'b1;
    repeat (3) @(negedge clk);

    // Normal pour: 3 units -> 12 out2 cycles
    amount2 = 8'd3;
    count2  = 1'b1;
    check_eq("norm_latency_pre", out2, 0);
    run_to_ack(100, outs, got_ack);
    check_eq("norm_ack_seen", got_ack, 1);
    check_eq("norm_out_cycles", outs, 12);
    check_eq("norm_out_off", out2, 0);
    check_eq("norm_poured", poured2, 3);
    check_eq("norm_aborted", aborted2, 0);
    count2 = 1'b0;
    @(negedge clk);
    check_eq("norm_ack_drop", count_ACK2, 0);
    check_eq("norm_busy_drop", busy2, 0);

    // Zero amount: immediate acknowledge
    amount2 = 8'd0;
    count2  = 1'b1;
    @(negedge clk);
    check_eq("zero_ack", count_ACK2, 1);
    check_eq("zero_out", out2, 0);
    check_eq("zero_poured", poured2, 0);
    count2 = 1'b0;
    @(negedge clk);
    check_eq("zero_ack_drop", count_ACK2, 0);

    // Abort on the 10th out2 cycle: 2 whole units delivered
    amount2 = 8'd5;
    count2  = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("abort_out_on", out2, 1);
    stop2 = 1'b1;
    @(negedge clk);
    stop2 = 1'b0;
    check_eq("abort_out_off", out2, 0);
    check_eq("abort_ack", count_ACK2, 1);
    check_eq("abort_flag", aborted2, 1);
    check_eq("abort_poured", poured2, 2);
    count2 = 1'b0;
    @(negedge clk);
    check_eq("abort_ack_drop", count_ACK2, 0);

    // Request withdrawn on the 3rd out2 cycle
    amount2 = 8'd5;
    count2  = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("wd_out_on", out2, 1);
    count2 = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    check_eq("wd_out_off", out2, 0);
    check_eq("wd_busy", busy2, 0);
    repeat (5) begin
      if (count_ACK2) seen = 1'b1;
      @(negedge clk);
    end
    check_eq("wd_no_ack", seen, 0);

    // Asynchronous reset mid-pour, then a 1-unit pour
    amount2 = 8'd5;
    count2  = 1'b1;
    repeat (3) @(negedge clk);
    #2 RESET = 1'b0;
    #1;
    check_eq("arst_out", out2, 0);
    check_eq("arst_busy", busy2, 0);
    check_eq("arst_ack", count_ACK2, 0);
    count2 = 1'b0;
    @(negedge clk);
    RESET = 1'b1;
    @(negedge clk);
    amount2 = 8'd1;
    count2  = 1'b1;
    run_to_ack(100, outs, got_ack);
    check_eq("arst_ack_seen", got_ack, 1);
    check_eq("arst_out_cycles", outs, 4);
    check_eq("arst_poured", poured2, 1);
    count2 = 1'b0;
    @(negedge clk);

    // Back-to-back: amount changes during POUR, count2 held through ACK
    amount2 = 8'd2;
    count2  = 1'b1;
    repeat (2) @(negedge clk);
    amount2 = 8'd7;
    run_to_ack(100, outs, got_ack);
    check_eq("b2b1_out_cycles", outs, 6);
    check_eq("b2b1_poured", poured2, 2);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out2 || !count_ACK2) seen = 1'b1;
    end
    check_eq("b2b_hold_no_restart", seen, 0);
    count2 = 1'b0;
    @(negedge clk);
    check_eq("b2b_ack_drop", count_ACK2, 0);
    count2 = 1'b1;
    run_to_ack(200, outs, got_ack);
    check_eq("b2b2_ack_seen", got_ack, 1);
    check_eq("b2b2_out_cycles", outs, 28);
    check_eq("b2b2_poured", poured2, 7);
    check_eq("b2b2_aborted", aborted2, 0);
    count2 = 1'b0;
    @(negedge clk);
    check_eq("b2b2_ack_drop", count_ACK2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
